img_bram_ctrl: RTL and testbench

- Sequences the single-port 64 KB pixel BRAM for one 28x28 image.
- Loads a streamed image (valid/ready) into BRAM addresses BASE_ADDR..BASE_ADDR+NUM_PIXELS-1.
- On request, replays the stored image to the first neural layer through a backpressured valid/ready stream.
- Sole owner of the BRAM port; write and read phases never overlap.

---
 rtl/img_ctrl_pkg.sv | 20 ++
 rtl/img_bram_ctrl_if.sv | 36 +++
 rtl/img_rd_fifo.sv | 44 ++++
 rtl/img_bram_ctrl.sv | 122 ++++++++++++
 tb/tb_img_bram_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/img_ctrl_pkg.sv
// Shared types and default sizes for the image BRAM controller.
// FIFO entries carry the pixel together with its index in the image.
package img_ctrl_pkg;

    localparam int unsigned DEF_NUM_PIXELS = 784;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_ADDR_W     = 16;

    typedef enum logic [1:0] {
        StLoad,
        StLoaded,
        StRead
    } ctrl_state_e;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] idx;
        logic [DEF_DATA_W-1:0] pix;
    } pix_entry_t;

endpackage

// File: rtl/img_bram_ctrl_if.sv
// Pixel input stream, pixel output stream, soft clear and BRAM port of the controller.
// slave is the controller's view, master the surrounding system's view.
interface img_bram_ctrl_if #(
    parameter int unsigned ADDR_W = img_ctrl_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = img_ctrl_pkg::DEF_DATA_W
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              start_read;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              image_loaded;
    logic              busy;
    logic              bram_we;
    logic              bram_re;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    modport slave (
        input  clear, in_valid, in_data, start_read, out_ready, bram_rdata,
        output in_ready, out_valid, out_data, out_index, out_last, image_loaded, busy,
        output bram_we, bram_re, bram_addr, bram_wdata
    );

    modport master (
        output clear, in_valid, in_data, start_read, out_ready, bram_rdata,
        input  in_ready, out_valid, out_data, out_index, out_last, image_loaded, busy,
        input  bram_we, bram_re, bram_addr, bram_wdata
    );
endinterface

// File: rtl/img_rd_fifo.sv
// Two-entry FIFO absorbing the BRAM read latency; head is presented directly.
module img_rd_fifo
    import img_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  pix_entry_t i_data,
    input  logic       i_pop,
    output pix_entry_t o_head,
    output logic [1:0] o_occ
);
    pix_entry_t r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;
endmodule

// File: rtl/img_bram_ctrl.sv
// Owns the pixel BRAM port: loads one streamed image, then replays it on request
// through a backpressured stream with a 2-entry read FIFO.
module img_bram_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned BASE_ADDR  = 0
) (
    input logic            clk,
    input logic            rst_n,
    img_bram_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W:0]   NumPix   = (ADDR_W + 1)'(NUM_PIXELS);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    if (NUM_PIXELS == 0 || (64'(BASE_ADDR) + 64'(NUM_PIXELS)) > (64'd1 << ADDR_W))
    begin : g_bad_range
        $error("img_bram_ctrl: image range exceeds the BRAM address space");
    end
    if (ADDR_W != DEF_ADDR_W || DATA_W != DEF_DATA_W) begin : g_bad_width
        $error("img_bram_ctrl: widths must match img_ctrl_pkg FIFO entry type");
    end

    ctrl_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_cnt, r_rd_cnt, r_rd_idx, r_wr_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_bram_we, r_rd_pend, r_image_loaded, r_busy;
    logic              w_in_hs, w_rd_issue, w_pop, w_push, w_out_valid, w_last_hs;
    logic [1:0]        w_occ;
    logic [2:0]        w_credit;
    pix_entry_t        w_head, w_push_entry;

    assign w_in_hs     = bus.in_valid & bus.in_ready;
    assign w_out_valid = (w_occ != 2'd0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_last_hs   = w_pop & (w_head.idx == LastIdx);

    // A pop in this cycle frees its slot in time for a read issued now, sustaining 1 pixel/cycle.
    assign w_credit   = {1'b0, w_occ} + {2'b0, r_rd_pend} - {2'b0, w_pop};
    assign w_rd_issue = (r_state == StRead) & ~bus.clear & ({1'b0, r_rd_cnt} < NumPix)
                      & (w_credit < 3'd2);

    assign w_push           = r_rd_pend & ~bus.clear;
    assign w_push_entry.idx = r_rd_idx;
    assign w_push_entry.pix = bus.bram_rdata;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear) begin
            w_state_nxt = StLoad;
        end else begin
            case (r_state)
                StLoad:   if (w_in_hs && r_wr_cnt == LastIdx) w_state_nxt = StLoaded;
                StLoaded: if (bus.start_read) w_state_nxt = StRead;
                StRead:   if (w_last_hs) w_state_nxt = StLoaded;
                default:  w_state_nxt = StLoad;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StLoad;
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_rd_idx       <= '0;
            r_rd_pend      <= 1'b0;
            r_bram_we      <= 1'b0;
            r_wr_addr      <= '0;
            r_wdata        <= '0;
            r_image_loaded <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_image_loaded <= (w_state_nxt != StLoad);
            r_busy         <= (w_state_nxt == StRead);
            r_bram_we      <= w_in_hs & ~bus.clear;
            r_rd_pend      <= w_rd_issue;
            if (w_in_hs && !bus.clear) begin
                r_wr_addr <= BaseAddr + r_wr_cnt;
                r_wdata   <= bus.in_data;
            end
            if (bus.clear) begin
                r_wr_cnt <= '0;
            end else if (w_in_hs) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (bus.clear || (r_state == StLoaded && bus.start_read)) begin
                r_rd_cnt <= '0;
            end else if (w_rd_issue) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
                r_rd_idx <= r_rd_cnt;
            end
        end
    end

    img_rd_fifo u_rd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.clear),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_occ   (w_occ)
    );

    assign bus.in_ready     = rst_n & (r_state == StLoad);
    assign bus.out_valid    = w_out_valid;
    assign bus.out_data     = w_head.pix;
    assign bus.out_index    = w_head.idx;
    assign bus.out_last     = w_out_valid & (w_head.idx == LastIdx);
    assign bus.image_loaded = r_image_loaded;
    assign bus.busy         = r_busy;
    assign bus.bram_we      = r_bram_we;
    assign bus.bram_re      = w_rd_issue;
    assign bus.bram_addr    = w_rd_issue ? (BaseAddr + r_rd_cnt) : r_wr_addr;
    assign bus.bram_wdata   = r_wdata;
endmodule

// File: tb/tb_img_bram_ctrl.sv
// Randomized bench for img_bram_ctrl: a transaction-level image model predicts
// BRAM writes and the replayed pixel sequence; a behavioural BRAM serves reads.
module tb_img_bram_ctrl;
    localparam int unsigned NPIX = 784;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned BASE = 0;
    localparam int MLoad = 0, MLoaded = 1, MRead = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    img_bram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    img_bram_ctrl #(
        .NUM_PIXELS (NPIX),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] bram [65536];
    always @(posedge clk) begin
        if (bus.bram_we) bram[bus.bram_addr] <= bus.bram_wdata;
        if (bus.bram_re) bus.bram_rdata <= bram[bus.bram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state of the image, expected writes, next expected pixel.
    int            m_state, m_wr_cnt, m_rd_next, m_replays, m_re_cnt;
    int            cyc, m_start_cyc, m_last_lat;
    bit            first_pending, prev_stall;
    logic [DW-1:0] m_img [NPIX];
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_idx;
    logic [23:0]   q_wr [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_state = MLoad; m_wr_cnt = 0; m_rd_next = 0;
        first_pending = 0; prev_stall = 0;
        q_wr.delete();
    endtask

    task automatic sample();
        logic [23:0] w;
        cyc++;
        check_eq("in_ready", bus.in_ready, m_state == MLoad);
        check_eq("image_loaded", bus.image_loaded, m_state != MLoad);
        check_eq("busy", bus.busy, m_state == MRead);
        check_eq("we_re_exclusive", bus.bram_we & bus.bram_re, 0);
        if (m_state != MRead) check_eq("re_outside_read", bus.bram_re, 0);
        if (m_state == MRead) check_eq("we_in_read", bus.bram_we, 0);
        if (bus.bram_re) m_re_cnt++;
        if (m_state == MRead && cyc - m_start_cyc == 1) begin
            check_eq("first_re", bus.bram_re, 1);
            check_eq("first_re_addr", bus.bram_addr, BASE);
        end
        if (bus.bram_we) begin
            if (q_wr.size() == 0) begin
                check_eq("spurious_write", bus.bram_we, 0);
            end else begin
                w = q_wr.pop_front();
                check_eq("wr_addr", bus.bram_addr, w[23:8]);
                check_eq("wr_data", bus.bram_wdata, w[7:0]);
            end
        end
        if (prev_stall) begin
            check_eq("stall_valid", bus.out_valid, 1);
            check_eq("stall_index", bus.out_index, prev_idx);
            check_eq("stall_data", bus.out_data, prev_data);
        end
        if (m_state != MRead) check_eq("out_valid_idle", bus.out_valid, 0);
        if (bus.out_valid && m_state == MRead) begin
            if (first_pending) begin
                check_eq("first_latency", cyc - m_start_cyc, 3);
                first_pending = 0;
            end
            check_eq("out_index", bus.out_index, m_rd_next);
            if (m_rd_next < NPIX) check_eq("out_data", bus.out_data, m_img[m_rd_next]);
            check_eq("out_last", bus.out_last, m_rd_next == NPIX - 1);
        end
        prev_stall = bus.out_valid & ~bus.out_ready;
        prev_idx   = bus.out_index;
        prev_data  = bus.out_data;
        if (bus.clear) begin
            m_state = MLoad; m_wr_cnt = 0; first_pending = 0; prev_stall = 0;
        end else begin
            case (m_state)
                MLoad: if (bus.in_valid) begin
                    q_wr.push_back({16'(BASE + m_wr_cnt), bus.in_data});
                    m_img[m_wr_cnt] = bus.in_data;
                    m_wr_cnt++;
                    if (m_wr_cnt == NPIX) m_state = MLoaded;
                end
                MLoaded: if (bus.start_read) begin
                    m_state = MRead; m_rd_next = 0; m_start_cyc = cyc; first_pending = 1;
                end
                default: if (bus.out_valid && bus.out_ready) begin
                    if (m_rd_next == NPIX - 1) begin
                        m_state = MLoaded; m_replays++; m_last_lat = cyc - m_start_cyc;
                    end
                    m_rd_next++;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.clear = 0; bus.in_valid = 0; bus.in_data = 0; bus.start_read = 0; bus.out_ready = 0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_last", bus.out_last, 0);
        check_eq("rst_out_index", bus.out_index, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_image_loaded", bus.image_loaded, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_bram_we", bus.bram_we, 0);
        check_eq("rst_bram_re", bus.bram_re, 0);
        check_eq("rst_bram_addr", bus.bram_addr, 0);
        check_eq("rst_bram_wdata", bus.bram_wdata, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        repeat (3) @(posedge clk);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", bus.in_ready, 1);
        check_eq("rel_image_loaded", bus.image_loaded, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int pattern);
        int guard = 0;
        while (m_state == MLoad && guard < 5000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = (pattern == 0) ? 8'(m_wr_cnt) : 8'(m_wr_cnt * 7 + 3);
            tick();
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (5) tick();
        bus.in_valid = 1'b0;
        check_eq("loaded_flag", bus.image_loaded, 1);
        check_eq("loaded_in_ready", bus.in_ready, 0);
    endtask

    // mode 0: out_ready held; 1: 10-cycle stall at 50 then random;
    // 2: random with stray start_read pulses; 3: clear at index 100
    task automatic read_image(input int mode);
        int guard = 0;
        bit stalled = 0;
        bus.out_ready  = 1'b1;
        bus.start_read = 1'b1;
        tick();
        bus.start_read = 1'b0;
        while (m_state == MRead && guard < 20000) begin
            if (mode == 1 && !stalled && m_rd_next >= 50) begin
                stalled = 1;
                bus.out_ready = 1'b0;
                m_re_cnt = 0;
                repeat (10) tick();
                check_eq("stall_reads_le2", m_re_cnt <= 2, 1);
            end
            if (mode == 3 && m_rd_next == 100) begin
                bus.clear = 1'b1;
                tick();
                bus.clear = 1'b0;
                check_eq("clr_out_valid", bus.out_valid, 0);
                check_eq("clr_busy", bus.busy, 0);
                check_eq("clr_image_loaded", bus.image_loaded, 0);
                check_eq("clr_in_ready", bus.in_ready, 1);
                return;
            end
            bus.out_ready  = ((mode == 1 && stalled) || mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start_read = (mode == 2 && (guard == 40 || guard == 400));
            tick();
            guard++;
        end
        bus.start_read = 1'b0;
        bus.out_ready  = 1'b1;
        check_eq("read_done", guard < 20000, 1);
        check_eq("read_busy_after", bus.busy, 0);
        check_eq("read_loaded_after", bus.image_loaded, 1);
    endtask

    initial begin
        int rep0;
        cyc = 0; m_replays = 0; m_re_cnt = 0; m_start_cyc = -100; m_last_lat = 0;
        do_reset();
        load_image(0);
        read_image(0);
        check_eq("replay_cycles", m_last_lat, 786);
        read_image(1);
        read_image(3);
        load_image(1);
        read_image(0);
        // stray start_read during LOAD and READ must be ignored
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start_read = 1'b1;
        tick();
        bus.start_read = 1'b0;
        load_image(0);
        rep0 = m_replays;
        read_image(2);
        check_eq("one_replay", m_replays - rep0, 1);
        read_image(0);
        check_eq("second_replay", m_replays - rep0, 2);
        // reset in the middle of a replay
        bus.start_read = 1'b1;
        tick();
        bus.start_read = 1'b0;
        repeat (200) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        do_reset();
        repeat (3) tick();
        check_eq("writes_pending", q_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
